reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement buffer feeding the RAT's rename-write and commit interface. Dispatch allocates one entry
//  per instruction and receives its ROB tag, which is written into the RAT. Execution units write results back
//  by tag. Completed entries retire strictly in program order from the head. Each retirement drives the
//  commit (en, rd, rob_addr, data) triple to the RAT and the register file.
// PARAMETERS
//  DEPTH   8   number of entries; power of 2, >= 2
//  ADDR_W  8   ROB tag port width; matches the RAT ROBSIZE port width; must be >= $clog2(DEPTH)
//  XLEN    32  result data width
// PORTS
//  clk               in   1        clock
//  rstn              in   1        reset, asynchronous, active-low
//  i_flush           in   1        discard all entries (mispredict/exception)
//  i_alloc_valid     in   1        dispatch requests an entry
//  i_alloc_rd        in   5        destination register of the dispatched instruction
//  o_alloc_ready     out  1        entry available (= !o_full)
//  o_alloc_rob_addr  out  ADDR_W   tag that the next accepted alloc receives (tail index, zero-extended)
//  i_wb_valid        in   1        result writeback strobe
//  i_wb_rob_addr     in   ADDR_W   writeback tag
//  i_wb_data         in   XLEN     writeback result
//  i_rs1_rob_addr    in   ADDR_W   operand lookup tag, port 1 (from RAT)
//  i_rs2_rob_addr    in   ADDR_W   operand lookup tag, port 2
//  o_rs1_ready       out  1        lookup-1 entry holds a result
//  o_rs1_data        out  XLEN     lookup-1 result
//  o_rs2_ready       out  1        lookup-2 entry holds a result
//  o_rs2_data        out  XLEN     lookup-2 result
//  o_commit_en       out  1        one-cycle retirement pulse
//  o_commit_rd       out  5        retired destination register
//  o_commit_rob_addr out  ADDR_W   retired tag
//  o_commit_data     out  XLEN     retired result
//  o_empty           out  1        count == 0
//  o_full            out  1        count == DEPTH
//  o_count           out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Storage per entry: valid, done, rd[4:0], data[XLEN-1:0]. Pointers: head and tail, $clog2(DEPTH) bits, wrap
//    modulo DEPTH. Tags use the low $clog2(DEPTH) bits; the upper tag bits are driven 0 and ignored on input.
//  - Reset (async): all valid and done bits = 0, head = tail = count = 0. Every o_commit_* output = 0.
//    o_empty = 1, o_full = 0, o_alloc_ready = 1, o_alloc_rob_addr = 0. Data contents are don't-care.
//  - Alloc: an alloc fires on the edge where i_alloc_valid & o_alloc_ready. The entry at tail is set to
//    valid = 1, done = 0, rd = i_alloc_rd, and tail advances by 1. o_alloc_ready does not look ahead to a
//    same-cycle commit, so a full ROB blocks alloc for that cycle.
//  - Writeback: on i_wb_valid with the addressed entry valid, set done = 1 and data = i_wb_data. A writeback to
//    an invalid entry is ignored. A writeback to the entry being allocated in the same cycle is illegal (SVA).
//  - Lookup (combinational): o_rsN_ready = valid & done for the addressed entry, and o_rsN_data = that entry's
//    data. Bypass: when i_wb_valid is set and the writeback tag equals the lookup tag for a valid entry, the
//    lookup port returns ready = 1 and data = i_wb_data.
//  - Commit (registered): at an edge where the head entry has valid & done, the block registers
//    o_commit_en = 1 and captures the head entry's rd, tag and data into o_commit_*. It then clears that entry's
//    valid and advances head.
//    * Otherwise o_commit_en = 0 and the other o_commit_* outputs hold their previous value.
//    * At most one commit per cycle.
//    * A head writeback in cycle N is seen as done at edge N+1, so the commit pulse appears at the earliest in
//      cycle N+2.
//    * Entries with rd = 0 still commit. Consumers ignore writes to x0.
//  - Count: +1 on alloc, -1 on commit, unchanged when both happen in the same cycle.
//  - Flush has priority over alloc, writeback and commit in the same cycle. At the next edge, all valid and
//    done bits = 0, head = tail = count = 0 and o_commit_en = 0. The RAT is flushed by the same i_flush.
//  - Async reset mid-operation returns the block immediately to the reset state, with no commit pulse.
// TESTING
//  1. Reset, then 8 allocs with rd = 1..8 -> tags 0..7. o_full = 1 and o_alloc_ready = 0 after the 8th.
//     A 9th alloc (rd = 9) is ignored and o_count stays 8.
//  2. Out-of-order writeback: tag2 = 0xAA, then tag0 = 0x11, then tag1 = 0x22 -> no commit before tag0 is done.
//     Then three consecutive pulses: (rd1, 0, 0x11), (rd2, 1, 0x22), (rd3, 2, 0xAA).
//  3. Wrap: fill 8 entries, retire 6, alloc 4 -> tags 0, 1, 2, 3 issued after 7. o_count = 6.
//     Retirement order is 6, 7, 0, 1, 2, 3.
//  4. Bypass: i_rs1_rob_addr = 3 with tag3 not done, and i_wb_valid for tag3 with data 0x55 in the same cycle
//     -> o_rs1_ready = 1, o_rs1_data = 0x55 in that cycle. The next cycle gives the same result from storage.
//  5. Flush with 5 entries (2 done) plus a simultaneous alloc -> next cycle o_count = 0, o_empty = 1 and no
//     commit pulse. The next alloc gets tag 0.
//  6. Full ROB, head done, alloc held high -> alloc blocked in the commit cycle and accepted one cycle later.
//     Assert rstn = 0 mid-stream -> outputs return to reset values immediately.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch allocates tags at the tail, execution writes results back by tag,
// completed entries retire one per cycle from the head onto the registered commit interface.

module reorder_buffer_chk #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          rstn,
  input logic          i_alloc,
  input logic          i_wb_valid,
  input logic [AW-1:0] i_wb_idx,
  input logic [AW-1:0] i_tail,
  input logic [CW-1:0] i_count
);
  a_wb_to_new_entry: assert property (@(posedge clk) disable iff (!rstn)
    !(i_alloc && i_wb_valid && (i_wb_idx == i_tail)));
  a_count_range: assert property (@(posedge clk) disable iff (!rstn)
    i_count <= CW'(DEPTH));
endmodule

module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_flush,
  input  logic              i_alloc_valid,
  input  logic [4:0]        i_alloc_rd,
  output logic              o_alloc_ready,
  output logic [ADDR_W-1:0] o_alloc_rob_addr,
  input  logic              i_wb_valid,
  input  logic [ADDR_W-1:0] i_wb_rob_addr,
  input  logic [XLEN-1:0]   i_wb_data,
  input  logic [ADDR_W-1:0] i_rs1_rob_addr,
  input  logic [ADDR_W-1:0] i_rs2_rob_addr,
  output logic              o_rs1_ready,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic              o_rs2_ready,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic              o_commit_en,
  output logic [4:0]        o_commit_rd,
  output logic [ADDR_W-1:0] o_commit_rob_addr,
  output logic [XLEN-1:0]   o_commit_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [4:0]        r_rd   [DEPTH];
  logic [XLEN-1:0]   r_data [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_commit_en;
  logic [4:0]        r_commit_rd;
  logic [ADDR_W-1:0] r_commit_addr;
  logic [XLEN-1:0]   r_commit_data;

  logic              w_full;
  logic              w_alloc;
  logic              w_commit;
  logic              w_wb;
  logic [AW-1:0]     w_wb_idx;
  logic [AW-1:0]     w_rs1_idx;
  logic [AW-1:0]     w_rs2_idx;
  logic [ADDR_W-1:0] w_tail_tag;
  logic [ADDR_W-1:0] w_head_tag;
  logic              w_unused_tag_bits;

  // Upper tag bits carry no information; the lookup/writeback index uses only the low bits.
  assign w_wb_idx  = i_wb_rob_addr[AW-1:0];
  assign w_rs1_idx = i_rs1_rob_addr[AW-1:0];
  assign w_rs2_idx = i_rs2_rob_addr[AW-1:0];
  assign w_unused_tag_bits = ^{i_wb_rob_addr, i_rs1_rob_addr, i_rs2_rob_addr};

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_alloc  = i_alloc_valid & ~w_full & ~i_flush;
  assign w_commit = r_valid[r_head] & r_done[r_head] & ~i_flush;
  assign w_wb     = i_wb_valid & r_valid[w_wb_idx] & ~i_flush;

  // Result lookup with same-cycle writeback bypass; returns {ready, data}.
  function automatic logic [XLEN:0] f_lookup(input logic [AW-1:0] idx);
    logic [XLEN:0] res;
    if (i_wb_valid && r_valid[idx] && (w_wb_idx == idx)) begin
      res = {1'b1, i_wb_data};
    end else begin
      res = {r_valid[idx] & r_done[idx], r_data[idx]};
    end
    return res;
  endfunction

  assign {o_rs1_ready, o_rs1_data} = f_lookup(w_rs1_idx);
  assign {o_rs2_ready, o_rs2_data} = f_lookup(w_rs2_idx);

  // Zero-extend the internal pointers to the external tag width.
  always_comb begin
    w_tail_tag = '0;
    w_head_tag = '0;
    w_tail_tag[AW-1:0] = r_tail;
    w_head_tag[AW-1:0] = r_head;
  end

  // Entry status bits; commit and alloc never target the same entry since head==tail implies empty or full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      r_done  <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_wb) begin
        r_done[w_wb_idx] <= 1'b1;
      end
      if (w_commit) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
      end
    end
  end

  // Payload storage, meaningful only while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_rd[r_tail] <= i_alloc_rd;
    end
    if (w_wb) begin
      r_data[w_wb_idx] <= i_wb_data;
    end
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_commit) begin
        r_head <= r_head + AW'(1);
      end
      if (w_alloc) begin
        r_tail <= r_tail + AW'(1);
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_commit);
    end
  end

  // Registered commit interface; payload holds its last value between pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_commit_en   <= 1'b0;
      r_commit_rd   <= 5'd0;
      r_commit_addr <= '0;
      r_commit_data <= '0;
    end else if (w_commit) begin
      r_commit_en   <= 1'b1;
      r_commit_rd   <= r_rd[r_head];
      r_commit_addr <= w_head_tag;
      r_commit_data <= r_data[r_head];
    end else begin
      r_commit_en   <= 1'b0;
    end
  end

  assign o_alloc_ready     = ~w_full;
  assign o_alloc_rob_addr  = w_tail_tag;
  assign o_full            = w_full;
  assign o_empty           = (r_count == CW'(0));
  assign o_count           = r_count;
  assign o_commit_en       = r_commit_en;
  assign o_commit_rd       = r_commit_rd;
  assign o_commit_rob_addr = r_commit_addr;
  assign o_commit_data     = r_commit_data;

  reorder_buffer_chk #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) u_chk (
    .clk        (clk),
    .rstn       (rstn),
    .i_alloc    (w_alloc),
    .i_wb_valid (i_wb_valid),
    .i_wb_idx   (w_wb_idx),
    .i_tail     (r_tail),
    .i_count    (r_count)
  );
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table for fill/out-of-order/bypass/flush,
// plus hand-written wrap, full-with-commit and mid-stream reset sequences.

module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        av = 1'b0;
  logic [4:0]  ard = 5'd0;
  logic        wv = 1'b0;
  logic [7:0]  wa = 8'd0;
  logic [31:0] wd = 32'd0;
  logic [7:0]  r1 = 8'd0;
  logic [7:0]  r2 = 8'd0;

  logic        alloc_ready, rs1_ready, rs2_ready, commit_en, empty, full;
  logic [7:0]  alloc_tag, commit_addr;
  logic [31:0] rs1_data, rs2_data, commit_data;
  logic [4:0]  commit_rd;
  logic [3:0]  count;

  int checks = 0;
  int failures = 0;
  logic [39:0] commit_q[$];

  reorder_buffer #(.DEPTH(8), .ADDR_W(8), .XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .i_flush(flush),
    .i_alloc_valid(av), .i_alloc_rd(ard), .o_alloc_ready(alloc_ready), .o_alloc_rob_addr(alloc_tag),
    .i_wb_valid(wv), .i_wb_rob_addr(wa), .i_wb_data(wd),
    .i_rs1_rob_addr(r1), .i_rs2_rob_addr(r2),
    .o_rs1_ready(rs1_ready), .o_rs1_data(rs1_data), .o_rs2_ready(rs2_ready), .o_rs2_data(rs2_data),
    .o_commit_en(commit_en), .o_commit_rd(commit_rd), .o_commit_rob_addr(commit_addr),
    .o_commit_data(commit_data), .o_empty(empty), .o_full(full), .o_count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f, av;
    logic [4:0]  ard;
    logic        wv;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [7:0]  r1;
    logic        e_rdy;
    logic [31:0] e_rdata;
    logic [3:0]  e_cnt;
    logic        e_cen;
    logic [4:0]  e_crd;
    logic [7:0]  e_caddr;
    logic [31:0] e_cdata;
    logic [7:0]  e_tag;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic f, input logic a, input logic [4:0] rd, input logic w, input logic [7:0] waddr,
                     input logic [31:0] wdata, input logic [7:0] l1, input logic erdy, input logic [31:0] edata,
                     input logic [3:0] ecnt, input logic ecen, input logic [4:0] ecrd, input logic [7:0] ecaddr,
                     input logic [31:0] ecdata, input logic [7:0] etag);
    vec_t v;
    v.f = f; v.av = a; v.ard = rd; v.wv = w; v.wa = waddr; v.wd = wdata; v.r1 = l1;
    v.e_rdy = erdy; v.e_rdata = edata; v.e_cnt = ecnt; v.e_cen = ecen; v.e_crd = ecrd;
    v.e_caddr = ecaddr; v.e_cdata = ecdata; v.e_tag = etag;
    vq.push_back(v);
  endtask

  task automatic drive(input logic a, input logic [4:0] rd, input logic w, input logic [7:0] waddr,
                       input logic [31:0] wdata);
    @(negedge clk);
    flush = 1'b0; av = a; ard = rd; wv = w; wa = waddr; wd = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (commit_en) commit_q.push_back({commit_addr, commit_data});
  endtask

  task automatic cyc(input logic a, input logic [4:0] rd, input logic w, input logic [7:0] waddr,
                     input logic [31:0] wdata);
    drive(a, rd, w, waddr, wdata);
    tick();
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, ".count"}, 40'(count), 40'd0);
    chk({nm, ".empty"}, 40'(empty), 40'd1);
    chk({nm, ".full"}, 40'(full), 40'd0);
    chk({nm, ".ready"}, 40'(alloc_ready), 40'd1);
    chk({nm, ".tag"}, 40'(alloc_tag), 40'd0);
    chk({nm, ".cen"}, 40'(commit_en), 40'd0);
    chk({nm, ".crd"}, 40'(commit_rd), 40'd0);
    chk({nm, ".caddr"}, 40'(commit_addr), 40'd0);
    chk({nm, ".cdata"}, 40'(commit_data), 40'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_tags [12];
    logic [7:0] order2 [6];
    vec_t v;

    // Reset state
    #2;
    chk_reset_state("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Fill 8 (tags 0..7), 9th blocked
    for (int i = 0; i < 8; i++)
      add(0, 1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 4'(i + 1), 0, 0, 0, 0, 8'((i + 1) % 8));
    add(0, 1, 9, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0);
    // Out-of-order writeback, then three consecutive commits
    add(0, 0, 0, 1, 2, 32'hAA, 2, 1, 32'hAA, 8, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h11, 2, 1, 32'hAA, 8, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 32'h22, 0, 1, 32'h11, 7, 1, 1, 0, 32'h11, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 32'h22, 6, 1, 2, 1, 32'h22, 0);
    add(0, 0, 0, 0, 0, 0, 2, 1, 32'hAA, 5, 1, 3, 2, 32'hAA, 0);
    add(0, 0, 0, 0, 0, 0, 2, 0, 0, 5, 0, 0, 0, 0, 0);
    // Bypass, then storage
    add(0, 0, 0, 1, 3, 32'h55, 3, 1, 32'h55, 5, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 1, 32'h55, 4, 1, 4, 3, 32'h55, 0);
    // Build 5 entries with two done (head among them), then flush with simultaneous alloc
    add(0, 1, 10, 1, 5, 32'h44, 5, 1, 32'h44, 5, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 4, 32'h77, 4, 1, 32'h77, 5, 0, 0, 0, 0, 1);
    add(1, 1, 11, 0, 0, 0, 5, 1, 32'h44, 0, 0, 0, 0, 0, 0);
    add(0, 1, 12, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 32'hC0, 0, 1, 32'hC0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'hC0, 0, 1, 12, 0, 32'hC0, 1);

    foreach (vq[i]) begin
      v = vq[i];
      @(negedge clk);
      flush = v.f; av = v.av; ard = v.ard; wv = v.wv; wa = v.wa; wd = v.wd; r1 = v.r1; r2 = v.r1;
      #1;
      chk($sformatf("v%0d.rs1_ready", i), 40'(rs1_ready), 40'(v.e_rdy));
      chk($sformatf("v%0d.rs2_ready", i), 40'(rs2_ready), 40'(v.e_rdy));
      if (v.e_rdy) begin
        chk($sformatf("v%0d.rs1_data", i), 40'(rs1_data), 40'(v.e_rdata));
        chk($sformatf("v%0d.rs2_data", i), 40'(rs2_data), 40'(v.e_rdata));
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.count", i), 40'(count), 40'(v.e_cnt));
      chk($sformatf("v%0d.empty", i), 40'(empty), 40'(v.e_cnt == 4'd0));
      chk($sformatf("v%0d.full", i), 40'(full), 40'(v.e_cnt == 4'd8));
      chk($sformatf("v%0d.ready", i), 40'(alloc_ready), 40'(v.e_cnt != 4'd8));
      chk($sformatf("v%0d.tag", i), 40'(alloc_tag), 40'(v.e_tag));
      chk($sformatf("v%0d.cen", i), 40'(commit_en), 40'(v.e_cen));
      if (v.e_cen) begin
        chk($sformatf("v%0d.crd", i), 40'(commit_rd), 40'(v.e_crd));
        chk($sformatf("v%0d.caddr", i), 40'(commit_addr), 40'(v.e_caddr));
        chk($sformatf("v%0d.cdata", i), 40'(commit_data), 40'(v.e_cdata));
      end
    end
    flush = 1'b0; r1 = 8'd0; r2 = 8'd0;

    // Wrap: fresh reset, fill 8, retire 6, alloc 4 -> tags 0..3, retire remaining in order
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1, 5'(i + 1), 0, 0, 0);
    commit_q.delete();
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 8'(i), 32'h100 + 32'(i));
    cyc(0, 0, 0, 0, 0);
    chk("wrap.count_after_retire", 40'(count), 40'd2);
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(20 + i), 0, 0, 0);
      #1;
      chk($sformatf("wrap.alloc_tag%0d", i), 40'(alloc_tag), 40'(i));
      tick();
    end
    chk("wrap.count", 40'(count), 40'd6);
    order2[0] = 8'd6; order2[1] = 8'd7; order2[2] = 8'd0;
    order2[3] = 8'd1; order2[4] = 8'd2; order2[5] = 8'd3;
    for (int i = 0; i < 6; i++)
      cyc(0, 0, 1, order2[i], (order2[i] >= 8'd6 ? 32'h100 : 32'h200) + 32'(order2[i]));
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) exp_tags[i] = 8'(i);
    for (int i = 0; i < 6; i++) exp_tags[6 + i] = order2[i];
    chk("wrap.commit_count", 40'(commit_q.size()), 40'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < commit_q.size())
        chk($sformatf("wrap.commit%0d", i), commit_q[i],
            {exp_tags[i], (i < 8 ? 32'h100 : 32'h200) + 32'(exp_tags[i])});
    end
    chk("wrap.empty", 40'(empty), 40'd1);

    // Full ROB with head completing while alloc is held high (head = tail = 4 here)
    for (int i = 0; i < 8; i++) cyc(1, 5'(i + 1), 0, 0, 0);
    chk("full.full", 40'(full), 40'd1);
    drive(1, 30, 1, 4, 32'hD4);
    #1;
    chk("full.ready_x0", 40'(alloc_ready), 40'd0);
    tick();
    chk("full.count_x0", 40'(count), 40'd8);
    chk("full.cen_x0", 40'(commit_en), 40'd0);
    drive(1, 30, 0, 0, 0);
    #1;
    chk("full.ready_x1", 40'(alloc_ready), 40'd0);
    tick();
    chk("full.cen_x1", 40'(commit_en), 40'd1);
    chk("full.caddr_x1", 40'(commit_addr), 40'd4);
    chk("full.crd_x1", 40'(commit_rd), 40'd1);
    chk("full.cdata_x1", 40'(commit_data), 40'hD4);
    chk("full.count_x1", 40'(count), 40'd7);
    drive(1, 30, 0, 0, 0);
    #1;
    chk("full.ready_x2", 40'(alloc_ready), 40'd1);
    chk("full.tag_x2", 40'(alloc_tag), 40'd4);
    tick();
    chk("full.count_x2", 40'(count), 40'd8);
    chk("full.full_x2", 40'(full), 40'd1);
    chk("full.cen_x2", 40'(commit_en), 40'd0);

    // Head-next completes, then async reset lands on the would-be commit cycle
    cyc(0, 0, 1, 5, 32'hE5);
    @(negedge clk);
    av = 1'b0; wv = 1'b0;
    rstn = 1'b0;
    #1;
    chk_reset_state("midreset");
    @(posedge clk);
    #1;
    chk("midreset.cen_edge", 40'(commit_en), 40'd0);
    @(negedge clk);
    rstn = 1'b1;
    r1 = 8'd5;
    #1;
    chk("midreset.lookup5", 40'(rs1_ready), 40'd0);
    tick();
    chk("midreset.cen_after", 40'(commit_en), 40'd0);
    chk("midreset.count_after", 40'(count), 40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
